// File: rtl/regfile_wb_driver.sv
// Write-back driver for the register file write port: arbitrates EXU/LSU results into an
// in-order FIFO, drains one write per cycle, and exposes a youngest-match pending-write lookup.
module regfile_wb_driver #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      exu_valid,
    output logic                      exu_ready,
    input  logic [ADDR_WIDTH-1:0]     exu_rd,
    input  logic [DATA_WIDTH-1:0]     exu_data,
    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [ADDR_WIDTH-1:0]     lsu_rd,
    input  logic [DATA_WIDTH-1:0]     lsu_data,
    input  logic                      wb_stall,
    output logic                      Regwr,
    output logic [ADDR_WIDTH-1:0]     Rw,
    output logic [DATA_WIDTH-1:0]     busW,
    input  logic [ADDR_WIDTH-1:0]     query_rd,
    output logic                      pend_hit,
    output logic [DATA_WIDTH-1:0]     pend_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {GrantExu, GrantLsu} grant_e;

    grant_e                last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         rptr_q, wptr_q;
    logic [CW-1:0]         count_q, count_d;

    logic                  full, empty;
    logic                  gnt_exu, gnt_lsu;
    logic                  exu_fire, lsu_fire;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] push_rd;
    logic [DATA_WIDTH-1:0] push_data;
    logic [PW-1:0]         idx;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Under contention the source that did not win the last handshake goes first.
    always_comb begin
        gnt_exu = exu_valid && (!lsu_valid || last_grant_q == GrantLsu);
        gnt_lsu = lsu_valid && (!exu_valid || last_grant_q == GrantExu);
    end

    // x0 results are always accepted (and dropped) even when the FIFO is full.
    assign exu_ready = rst_n && gnt_exu && (!full || exu_rd == '0);
    assign lsu_ready = rst_n && gnt_lsu && (!full || lsu_rd == '0);
    assign exu_fire  = exu_valid && exu_ready;
    assign lsu_fire  = lsu_valid && lsu_ready;

    always_comb begin
        push_rd   = exu_fire ? exu_rd : lsu_rd;
        push_data = exu_fire ? exu_data : lsu_data;
        push      = (exu_fire || lsu_fire) && (push_rd != '0);
    end

    assign pop   = !empty && !wb_stall;
    assign Regwr = pop;
    assign Rw    = empty ? '0 : rd_q[rptr_q];
    assign busW  = empty ? '0 : data_q[rptr_q];
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (exu_fire) begin
            last_grant_d = GrantExu;
        end else if (lsu_fire) begin
            last_grant_d = GrantLsu;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        pend_hit  = 1'b0;
        pend_data = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rptr_q + PW'(i);
            if (CW'(i) < count_q && query_rd != '0 && rd_q[idx] == query_rd) begin
                pend_hit  = 1'b1;
                pend_data = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            last_grant_q <= GrantExu;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                rd_q[wptr_q]   <= push_rd;
                data_q[wptr_q] <= push_data;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_driver.sv
// Self-checking bench for regfile_wb_driver: directed scenarios plus random traffic,
// all checked each cycle against a queue-based reference model.
module tb_regfile_wb_driver;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          exu_valid, lsu_valid, wb_stall;
    logic          exu_ready, lsu_ready;
    logic [AW-1:0] exu_rd, lsu_rd, query_rd, Rw;
    logic [DW-1:0] exu_data, lsu_data, busW, pend_data;
    logic          Regwr, pend_hit;
    logic [2:0]    count;

    regfile_wb_driver #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_stall(wb_stall), .Regwr(Regwr), .Rw(Rw), .busW(busW),
        .query_rd(query_rd), .pend_hit(pend_hit), .pend_data(pend_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    entry_t model_q[$];
    bit     last_was_lsu;   // false after reset: the last grant counts as EXU
    bit     exp_er, exp_lr;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_writes = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        last_was_lsu = 1'b0;
    endtask

    // Called at the falling edge with inputs already driven; checks, then advances one cycle.
    task automatic cycle();
        bit            full, ge, gl, ewr;
        logic [AW-1:0] erw;
        logic [DW-1:0] ebus, epd;
        bit            ehit;
        #1;
        full = (model_q.size() == DEPTH);
        ge   = exu_valid && (!lsu_valid || last_was_lsu);
        gl   = lsu_valid && (!exu_valid || !last_was_lsu);
        exp_er = ge && (!full || exu_rd == 0);
        exp_lr = gl && (!full || lsu_rd == 0);
        ewr  = (model_q.size() != 0) && !wb_stall;
        erw  = (model_q.size() != 0) ? model_q[0].rd : '0;
        ebus = (model_q.size() != 0) ? model_q[0].data : '0;
        ehit = 1'b0;
        epd  = '0;
        foreach (model_q[i]) begin
            if (query_rd != 0 && model_q[i].rd == query_rd) begin
                ehit = 1'b1;
                epd  = model_q[i].data;
            end
        end
        check_eq("exu_ready", exu_ready, exp_er);
        check_eq("lsu_ready", lsu_ready, exp_lr);
        check_eq("Regwr", Regwr, ewr);
        check_eq("Rw", Rw, erw);
        check_eq("busW", busW, ebus);
        check_eq("pend_hit", pend_hit, ehit);
        check_eq("pend_data", pend_data, epd);
        check_eq("count", count, model_q.size());
        check_eq("no_x0_write", Regwr && Rw == 0, 0);
        @(posedge clk);
        if (ewr) begin
            void'(model_q.pop_front());
            n_writes++;
        end
        if (exu_valid && exp_er) begin
            last_was_lsu = 1'b0;
            if (exu_rd != 0) model_q.push_back('{rd: exu_rd, data: exu_data});
        end else if (lsu_valid && exp_lr) begin
            last_was_lsu = 1'b1;
            if (lsu_rd != 0) model_q.push_back('{rd: lsu_rd, data: lsu_data});
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        exu_valid = 0; lsu_valid = 0; exu_rd = 0; lsu_rd = 0;
        exu_data = 0; lsu_data = 0; query_rd = 0;
    endtask

    initial begin
        idle_inputs();
        wb_stall = 0;
        rst_n = 0;
        model_reset();
        #1;
        check_eq("rst_regwr", Regwr, 0);
        check_eq("rst_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        cycle();

        // Single EXU result, written one cycle later.
        exu_valid = 1; exu_rd = 5; exu_data = 32'h11;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        check_eq("single_write_count", n_writes, 1);

        // Fill under stall with alternating sources; fifth waits until space frees up.
        wb_stall = 1;
        for (int k = 1; k <= 5; k++) begin
            idle_inputs();
            if (k % 2 == 1) begin exu_valid = 1; exu_rd = AW'(k); exu_data = 32'(k * 16); end
            else begin lsu_valid = 1; lsu_rd = AW'(k); lsu_data = 32'(k * 16); end
            cycle();
            if (k == 5) check_eq("fifth_blocked", exp_er, 0);
        end
        check_eq("fill_count", count, DEPTH);
        wb_stall = 0;
        for (int t = 0; t < 10 && !exp_er; t++) cycle();
        check_eq("fifth_accepted", exp_er, 1);
        idle_inputs();
        repeat (6) cycle();

        // Continuous contention: round robin starting from the source not granted last.
        exu_valid = 1; exu_rd = 2; lsu_valid = 1; lsu_rd = 3;
        for (int t = 0; t < 8; t++) begin
            exu_data = $urandom; lsu_data = $urandom;
            cycle();
        end
        idle_inputs();
        repeat (4) cycle();

        // Two writes to the same register: lookup forwards the younger one.
        wb_stall = 1;
        exu_valid = 1; exu_rd = 7; exu_data = 32'hA;
        cycle();
        exu_data = 32'hB;
        cycle();
        idle_inputs();
        query_rd = 7;
        cycle();
        check_eq("fwd_hit", pend_hit, 1);
        check_eq("fwd_data", pend_data, 32'hB);
        query_rd = 0;
        cycle();
        wb_stall = 0;
        repeat (4) cycle();

        // x0 results are consumed without occupying space, even when full.
        wb_stall = 1;
        for (int k = 0; k < DEPTH; k++) begin
            exu_valid = 1; exu_rd = AW'(k + 10); exu_data = $urandom;
            cycle();
        end
        exu_rd = 0; exu_data = 32'hFF;
        cycle();
        check_eq("x0_ready_full", exp_er, 1);
        idle_inputs();
        cycle();
        check_eq("x0_count", count, DEPTH);
        wb_stall = 0;
        repeat (6) cycle();

        // Asynchronous reset with entries queued.
        wb_stall = 1;
        for (int k = 0; k < 3; k++) begin
            lsu_valid = 1; lsu_rd = AW'(k + 20); lsu_data = $urandom;
            cycle();
        end
        idle_inputs();
        wb_stall = 0;
        #2;
        rst_n = 0;
        #1;
        check_eq("async_rst_regwr", Regwr, 0);
        check_eq("async_rst_count", count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        n_writes = 0;
        repeat (4) cycle();
        check_eq("no_write_after_rst", n_writes, 0);

        // Random traffic.
        for (int t = 0; t < 2000; t++) begin
            exu_valid = ($urandom_range(0, 99) < 60);
            lsu_valid = ($urandom_range(0, 99) < 50);
            exu_rd    = AW'($urandom_range(0, 7));
            lsu_rd    = AW'($urandom_range(0, 7));
            exu_data  = $urandom;
            lsu_data  = $urandom;
            wb_stall  = ($urandom_range(0, 99) < 35);
            query_rd  = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_driver.md
Name: regfile_wb_driver

Overview:
- Write-back driver feeding the register file write port (Regwr/Rw/busW); the writer-side counterpart of the register file.
- Accepts write-back results from EXU and LSU over valid/ready channels.
- Arbitrates the two sources, buffers results in an in-order FIFO, and drains one write per cycle unless stalled.
- Provides a pending-write lookup with youngest-match data forwarding for hazard and bypass logic.

Parameters:
- ADDR_WIDTH, 5: register index width.
- DATA_WIDTH, 32: register data width.
- DEPTH, 4: FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exu_valid  in  1  EXU result valid.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid  in  1  LSU load result valid.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU load data.
- wb_stall  in  1  freeze draining; FIFO head is held.
- Regwr  out  1  register file write enable.
- Rw  out  ADDR_WIDTH  register file write address.
- busW  out  DATA_WIDTH  register file write data.
- query_rd  in  ADDR_WIDTH  register index to check for pending writes.
- pend_hit  out  1  a buffered write to query_rd exists.
- pend_data  out  DATA_WIDTH  data of the youngest matching entry.
- count  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): read/write pointers and count cleared; last_grant=EXU; entries discarded.
  - Outputs during and after reset: Regwr=0, Rw=0, busW=0, pend_hit=0, pend_data=0, count=0, exu_ready=0, lsu_ready=0.
  - Reset mid-operation drops all buffered writes; no partial write is issued.
- Arbitration (combinational), at most one acceptance per cycle:
  - Only one source valid: that source is granted.
  - Both valid: round-robin; the source not granted last is granted. First contention after reset goes to LSU.
  - last_grant updates only on a completed handshake.
- Ready: src_ready = granted && (!full || src_rd==0). Ready never depends on a same-cycle pop. Sources must not make valid depend on ready.
- Handshake: valid && ready at a rising edge.
  - rd!=0: {rd,data} pushed at tail.
  - rd==0: consumed and discarded; count unchanged; no Regwr is ever generated for x0.
- Drain: Regwr = (count!=0) && !wb_stall; Rw/busW = head entry, combinational.
  - Head pops at the edge where Regwr=1; the register file writes on that same edge.
  - Latency: accepted at edge N, written at edge N+1 minimum with empty FIFO and no stall.
  - Rw/busW show the head contents while count!=0, else 0.
- Simultaneous push and pop: count unchanged; pointers advance modulo DEPTH and wrap silently.
- Full (count==DEPTH): both readys low for rd!=0. Empty: Regwr=0.
- Order: strict FIFO; multiple writes to the same rd retire oldest first, so the last accepted value wins.
- Lookup (combinational):
  - pend_hit=1 iff query_rd!=0 and any occupied entry has rd==query_rd.
  - pend_data = data of the youngest such entry, else 0.
  - The head entry counts as pending, even in its Regwr cycle.
  - Entries being pushed this cycle are not visible until the next cycle.
- count = number of occupied entries, 0..DEPTH.

Test Plan:
- Reset, then EXU rd=5 data=0x11 for one cycle -> exu_ready=1; next cycle Regwr=1, Rw=5, busW=0x11; then count=0 and Regwr=0.
- wb_stall=1; push EXU/LSU alternately 5 times with rd=1..5 -> 4 accepted, 5th sees ready=0 and count=4. Release stall -> Rw sequence 1,2,3,4 on consecutive cycles, then the 5th accepted and written.
- Both valid continuously (EXU rd=2, LSU rd=3), no stall -> grants alternate LSU, EXU, LSU...; Rw alternates 3,2,3.
- wb_stall=1; push rd=7 data=0xA then rd=7 data=0xB; query_rd=7 -> pend_hit=1, pend_data=0xB. query_rd=0 -> pend_hit=0. Unstall -> writes 0xA then 0xB.
- EXU rd=0 data=0xFF while FIFO full -> exu_ready=1, count unchanged, no Regwr with Rw=0 ever.
- Pulse rst_n=0 with 3 entries queued -> Regwr=0 and count=0 immediately, without a clock edge; no further writes after release.
